// File: rtl/ram_piksel_besleyici.sv
// Streams one W x H frame of pixels out of a synchronous-read RAM into a ready/valid
// downstream port, with row/column/frame markers and a frame-complete pulse.
module ram_piksel_besleyici #(
    parameter int unsigned V = 8,
    parameter int unsigned W = 320,
    parameter int unsigned H = 240,
    parameter int unsigned A = 17
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic         ram_en_o,
    output logic [A-1:0] ram_addr_o,
    input  logic [V-1:0] ram_data_i,
    output logic [V-1:0] veri_o,
    output logic         veri_gecerli_o,
    input  logic         veri_al_i,
    output logic         satir_basi_o,
    output logic         satir_sonu_o,
    output logic         kare_sonu_o,
    output logic         mesgul_o,
    output logic         bitti_o
);

    localparam int unsigned NPix = W * H;
    localparam int unsigned CW   = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned RW   = (H > 1) ? $clog2(H) : 1;

    // One spare address bit so the "all pixels requested" value never aliases to 0.
    localparam logic [A:0]    PixCnt  = (A + 1)'(NPix);
    localparam logic [CW-1:0] ColLast = CW'(W - 1);
    localparam logic [RW-1:0] RowLast = RW'(H - 1);

    typedef enum logic [1:0] {
        StBosta,
        StOku,
        StSon
    } state_e;

    state_e        state_q, state_d;
    logic [A:0]    addr_q, addr_d;
    logic          infl_q, infl_d;
    logic [V-1:0]  mem_q [2];
    logic [V-1:0]  mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic          valid;
    logic          xfer;
    logic          push;
    logic          last_pix;
    logic          rd_ok;
    logic [2:0]    credit;

    assign valid    = (cnt_q != 2'd0);
    assign xfer     = valid && veri_al_i;
    assign push     = infl_q && (state_q == StOku);
    assign last_pix = (col_q == ColLast) && (row_q == RowLast);

    // A slot being drained this cycle is already free for a new read; this keeps one pixel
    // per cycle with a 2-entry buffer while buffered + in-flight never exceeds 2.
    assign credit = 3'(cnt_q) + 3'(infl_q) - 3'(xfer);
    assign rd_ok  = (state_q == StOku) && (addr_q < PixCnt) && (credit < 3'd2);

    assign ram_en_o       = rd_ok;
    assign ram_addr_o     = addr_q[A-1:0];
    assign veri_gecerli_o = valid;
    assign veri_o         = valid ? mem_q[rd_ptr_q] : '0;
    assign satir_basi_o   = valid && (col_q == '0);
    assign satir_sonu_o   = valid && (col_q == ColLast);
    assign kare_sonu_o    = valid && last_pix;
    assign mesgul_o       = (state_q != StBosta);
    assign bitti_o        = (state_q == StSon);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q + (A + 1)'(rd_ok);
        infl_d   = rd_ok;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + 2'(push) - 2'(xfer);
        col_d    = col_q;
        row_d    = row_q;

        if (push) begin
            mem_d[wr_ptr_q] = ram_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (xfer) begin
            rd_ptr_d = ~rd_ptr_q;
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        unique case (state_q)
            StBosta: begin
                if (en_i) begin
                    state_d  = StOku;
                    addr_d   = '0;
                    infl_d   = 1'b0;
                    cnt_d    = '0;
                    wr_ptr_d = 1'b0;
                    rd_ptr_d = 1'b0;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            StOku: begin
                if (xfer && last_pix) begin
                    state_d = StSon;
                end
            end
            StSon: begin
                state_d = StBosta;
            end
            default: begin
                state_d = StBosta;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StBosta;
            addr_q   <= '0;
            infl_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            infl_q   <= infl_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

endmodule

// File: tb/tb_ram_piksel_besleyici.sv
// Bench for ram_piksel_besleyici on a 20x15 frame: frame-level model of the pixel stream,
// checked every cycle, plus hand-computed per-frame totals.
module tb_ram_piksel_besleyici;

    localparam int unsigned V = 8;
    localparam int unsigned W = 20;
    localparam int unsigned H = 15;
    localparam int unsigned A = 9;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic         veri_al_i;
    logic         ram_en_o;
    logic [A-1:0] ram_addr_o;
    logic [V-1:0] ram_data;
    logic [V-1:0] veri_o;
    logic         veri_gecerli_o;
    logic         satir_basi_o;
    logic         satir_sonu_o;
    logic         kare_sonu_o;
    logic         mesgul_o;
    logic         bitti_o;

    ram_piksel_besleyici #(
        .V(V),
        .W(W),
        .H(H),
        .A(A)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .ram_en_o      (ram_en_o),
        .ram_addr_o    (ram_addr_o),
        .ram_data_i    (ram_data),
        .veri_o        (veri_o),
        .veri_gecerli_o(veri_gecerli_o),
        .veri_al_i     (veri_al_i),
        .satir_basi_o  (satir_basi_o),
        .satir_sonu_o  (satir_sonu_o),
        .kare_sonu_o   (kare_sonu_o),
        .mesgul_o      (mesgul_o),
        .bitti_o       (bitti_o)
    );

    always #5 clk = ~clk;

    // RAM holding RAM[a] = a mod 256, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en_o) ram_data <= ram_addr_o[V-1:0];
    end

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;

    // Frame-level model: which pixel must appear next, which address must be read next.
    bit rst_prev = 1'b0;
    bit busy_m = 1'b0;
    bit son_m = 1'b0;
    bit hold_prev = 1'b0;
    logic [V-1:0] prev_veri = '0;
    int exp_idx = 0;
    int exp_addr = 0;
    int issued = 0;
    int xfers = 0;
    int since = 0;
    int n_bitti = 0;
    int bitti_cyc = 0;
    int start_cyc = 0;
    int fr_xfers = 0;
    int fr_sosu = 0;
    int fr_basi = 0;
    int fr_kare = 0;
    logic [V-1:0] fr_last = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic check_and_update();
        bit xfer;
        if (rst_prev) begin
            chk("rst_ram_en", 32'(ram_en_o), 0);
            chk("rst_ram_addr", 32'(ram_addr_o), 0);
            chk("rst_veri", 32'(veri_o), 0);
            chk("rst_valid", 32'(veri_gecerli_o), 0);
            chk("rst_flags", 32'({satir_basi_o, satir_sonu_o, kare_sonu_o}), 0);
            chk("rst_mesgul", 32'(mesgul_o), 0);
            chk("rst_bitti", 32'(bitti_o), 0);
        end else begin
            chk("bitti", 32'(bitti_o), 32'(son_m));
            if (bitti_o) begin
                n_bitti++;
                bitti_cyc = cyc;
            end
            chk("mesgul", 32'(mesgul_o), 32'(busy_m));
            if (!busy_m) begin
                chk("idle_ram_en", 32'(ram_en_o), 0);
                chk("idle_valid", 32'(veri_gecerli_o), 0);
            end else if (!son_m) begin
                chk("occupancy_le2", 32'((issued - xfers) <= 2), 1);
                if (since == 1) begin
                    chk("lat_ram_en", 32'(ram_en_o), 1);
                    chk("lat_addr0", 32'(ram_addr_o), 0);
                end
                if (since == 3) chk("lat_valid", 32'(veri_gecerli_o), 1);
            end
            if (ram_en_o) begin
                chk("ram_addr", 32'(ram_addr_o), 32'(exp_addr));
                chk("addr_in_range", 32'(int'(ram_addr_o) < N), 1);
            end
            if (veri_gecerli_o) begin
                chk("pixel", 32'(veri_o), 32'(exp_idx % 256));
                chk("flags", 32'({satir_basi_o, satir_sonu_o, kare_sonu_o}),
                    32'({(exp_idx % W) == 0, (exp_idx % W) == W - 1, exp_idx == N - 1}));
                if (hold_prev) chk("stall_stable", 32'(veri_o), 32'(prev_veri));
            end else begin
                chk("flags_idle", 32'({satir_basi_o, satir_sonu_o, kare_sonu_o}), 0);
            end
        end

        xfer = veri_gecerli_o && veri_al_i;
        hold_prev = veri_gecerli_o && !veri_al_i;
        prev_veri = veri_o;
        if (rst_i) begin
            rst_prev = 1'b1;
            busy_m = 1'b0;
            son_m = 1'b0;
            hold_prev = 1'b0;
        end else begin
            rst_prev = 1'b0;
            if (son_m) begin
                son_m = 1'b0;
                busy_m = 1'b0;
            end else if (!busy_m) begin
                if (en_i) begin
                    busy_m = 1'b1;
                    exp_idx = 0;
                    exp_addr = 0;
                    issued = 0;
                    xfers = 0;
                    since = 1;
                    start_cyc = cyc;
                    fr_xfers = 0;
                    fr_sosu = 0;
                    fr_basi = 0;
                    fr_kare = 0;
                end
            end else begin
                since++;
                if (ram_en_o) begin
                    issued++;
                    exp_addr++;
                end
                if (xfer) begin
                    fr_xfers++;
                    if (satir_sonu_o) fr_sosu++;
                    if (satir_basi_o) fr_basi++;
                    if (kare_sonu_o) fr_kare++;
                    fr_last = veri_o;
                    if (exp_idx == N - 1) son_m = 1'b1;
                    exp_idx++;
                    xfers++;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready; 1: random ready with low bursts; 2: as 1 plus toggling en_i;
    // 3: always ready, en_i left as is. kill_at >= 0 asserts reset after that many transfers.
    task automatic run_frame(input int mode, input int kill_at);
        int b0;
        bit killed;
        b0 = n_bitti;
        killed = 1'b0;
        for (int t = 0; t < 4000 && n_bitti == b0; t++) begin
            if (mode == 0 || mode == 3) veri_al_i = 1'b1;
            else if ((t % 60) >= 50) veri_al_i = 1'b0;
            else veri_al_i = 1'($urandom_range(0, 1));
            if (mode == 2) en_i = ((t % 2) == 1);
            if (kill_at >= 0 && fr_xfers == kill_at) begin
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                killed = 1'b1;
                break;
            end
            tick();
        end
        if (mode == 2) en_i = 1'b0;
        if (!killed) chk("frame_done", 32'(n_bitti - b0), 1);
    endtask

    task automatic frame_literals(input bit check_cycles);
        chk("fr_transfers", 32'(fr_xfers), 300);
        chk("fr_satir_sonu", 32'(fr_sosu), 15);
        chk("fr_satir_basi", 32'(fr_basi), 15);
        chk("fr_kare_sonu", 32'(fr_kare), 1);
        chk("fr_last_value", 32'(fr_last), 43);
        if (check_cycles) chk("frame_cycles", 32'(bitti_cyc - start_cyc), 303);
    endtask

    initial begin
        int b1;
        rst_i = 1'b1;
        en_i = 1'b0;
        veri_al_i = 1'b0;
        @(posedge clk);
        #1;
        rst_prev = 1'b1;

        // Reset dominates en_i and veri_al_i.
        en_i = 1'b1;
        veri_al_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        en_i = 1'b0;
        repeat (2) tick();

        // Full-speed frame.
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
        run_frame(0, -1);
        frame_literals(1'b1);
        repeat (3) tick();

        // Backpressure.
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
        run_frame(1, -1);
        frame_literals(1'b0);
        repeat (2) tick();

        // Mid-frame reset, then a clean frame from address 0.
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
        run_frame(0, 100);
        tick();
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
        run_frame(0, -1);
        frame_literals(1'b1);
        repeat (2) tick();

        // en_i toggling during the frame must not restart it.
        b1 = n_bitti;
        en_i = 1'b1;
        tick();
        run_frame(2, -1);
        frame_literals(1'b0);
        repeat (5) tick();
        chk("single_bitti", 32'(n_bitti - b1), 1);
        chk("no_restart", 32'(mesgul_o), 0);

        // en_i held high: back-to-back frames separated by SON and one BOSTA cycle.
        en_i = 1'b1;
        tick();
        run_frame(3, -1);
        b1 = bitti_cyc;
        run_frame(3, -1);
        chk("b2b_gap", 32'(start_cyc - b1), 1);
        frame_literals(1'b1);
        en_i = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_piksel_besleyici.md
RAM_PIKSEL_BESLEYICI -- requirements
Module: ram_piksel_besleyici

Interface
REQ-001 Parameter V, default 8: pixel width in bits.
REQ-002 Parameter W, default 320: image width in pixels.
REQ-003 Parameter H, default 240: image height in pixels.
REQ-004 Parameter A, default 17: RAM address width; 2^A SHALL be at least W*H.
REQ-005 clk_i  in  1  single clock; all logic on the rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 en_i  in  1  frame start request, sampled only in BOSTA.
REQ-008 ram_en_o  out  1  RAM read enable.
REQ-009 ram_addr_o  out  A  RAM read address; the RAM has 1-cycle synchronous read latency.
REQ-010 ram_data_i  in  V  RAM read data, valid the cycle after ram_en_o.
REQ-011 veri_o  out  V  pixel to downstream stage.
REQ-012 veri_gecerli_o  out  1  veri_o valid.
REQ-013 veri_al_i  in  1  downstream ready; transfer = veri_gecerli_o && veri_al_i at a rising edge.
REQ-014 satir_basi_o / satir_sonu_o  out  1 each  current veri_o is column 0 / column W-1.
REQ-015 kare_sonu_o  out  1  current veri_o is pixel W*H-1.
REQ-016 mesgul_o  out  1  frame in progress (state OKU or SON).
REQ-017 bitti_o  out  1  one-cycle frame-complete pulse.

Function
REQ-018 The FSM SHALL have exactly the states BOSTA, OKU and SON.
REQ-019 BOSTA: en_i=1 at an edge SHALL go to OKU and clear the read address, output counter and buffer; en_i=0 keeps BOSTA.
REQ-020 en_i SHALL be ignored in OKU and SON.
REQ-021 OKU: in a cycle, ram_en_o=1 only when read address < W*H and (buffer occupancy + reads in flight) < 2; the address increments by 1 per issued read.
REQ-022 Read data SHALL be written into a 2-entry FIFO the cycle after issue; no pixel is dropped, duplicated or reordered.
REQ-023 veri_gecerli_o=1 iff the FIFO is non-empty; veri_o = FIFO head, held stable until transferred.
REQ-024 With veri_al_i held at 1, throughput SHALL be one pixel per cycle after the first.
REQ-025 Latency: en_i sampled at edge k -> ram_en_o=1 with address 0 after edge k; veri_gecerli_o=1 with pixel 0 after edge k+2.
REQ-026 A column counter (0..W-1) and a row counter (0..H-1) SHALL advance on each transfer; column wraps W-1 -> 0 and increments the row.
REQ-027 The flags of REQ-014/015 SHALL be decoded from those counters and SHALL be 0 whenever veri_gecerli_o=0.
REQ-028 The transfer of pixel W*H-1 SHALL move the FSM to SON; SON asserts bitti_o=1 for exactly one cycle and then returns to BOSTA.
REQ-029 en_i=1 in the BOSTA cycle following SON SHALL start a new frame from address 0.
REQ-030 A RAM read and a downstream transfer in the same cycle SHALL leave occupancy unchanged; the occupancy limit of 2 is never exceeded.
REQ-031 ram_addr_o SHALL never exceed W*H-1 while ram_en_o=1.

Reset
REQ-032 rst_i=1 at an edge SHALL force: state BOSTA; ram_en_o, veri_gecerli_o, satir_basi_o, satir_sonu_o, kare_sonu_o, mesgul_o, bitti_o all 0; ram_addr_o 0; veri_o 0; counters and FIFO cleared.
REQ-033 rst_i SHALL take priority over en_i and veri_al_i.
REQ-034 rst_i mid-frame SHALL discard in-flight RAM data; the next frame starts at address 0.

Verification
REQ-035 Reset: hold rst_i 3 cycles with en_i=1 and veri_al_i=1 -> all outputs 0 and no ram_en_o pulse.
REQ-036 Full frame: RAM[a] = a mod 256, 1-cycle en_i pulse, veri_al_i=1 -> veri_gecerli_o at edge k+2; 76800 consecutive transfers with values a mod 256; last value 255 with kare_sonu_o=1; 240 satir_sonu_o pulses; bitti_o pulses once, one cycle after the final transfer.
REQ-037 Backpressure: random veri_al_i (50%), plus 10-cycle low bursts -> veri_o stable while stalled; output sequence identical to REQ-036; reads in flight + buffered never above 2.
REQ-038 Mid-frame reset at transfer 1000 -> outputs reset next cycle; after a new en_i the first pixel is RAM[0] and 76800 pixels follow.
REQ-039 en_i toggled during OKU -> no restart; address sequence unaffected; bitti_o pulses once.
REQ-040 W=4, H=2: satir_basi_o on pixels 0 and 4; satir_sonu_o on pixels 3 and 7; kare_sonu_o on pixel 7; en_i held high -> back-to-back frames separated by the SON and BOSTA cycles.
